// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: I/O window base, register offsets
// inside the window and the hex font used by the 7-segment scanner.
package mmio_pkg;

  localparam logic [31:0] IO_BASE = 32'hFFFF_FC00;

  localparam logic [9:0] ADDR_LED   = 10'h060;
  localparam logic [9:0] ADDR_SW    = 10'h070;
  localparam logic [9:0] ADDR_SEG   = 10'h080;
  localparam logic [9:0] ADDR_BLANK = 10'h084;
  localparam logic [9:0] ADDR_BTN   = 10'h090;

  // Active-low segments {g,f,e,d,c,b,a}; listed from glyph F down to glyph 0.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/mmio_responder_if.sv
// CPU-side access port of the MMIO responder: one access per clock, no stall.
interface mmio_responder_if;
  // No valid/ready pair: io_read/io_write qualify the access for the current
  // cycle only, the responder never stalls, and rdata is combinational.
  logic        io_read;
  logic        io_write;
  logic [9:0]  addr_low;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output io_read, io_write, addr_low, wdata, input rdata);
  modport slave  (input io_read, io_write, addr_low, wdata, output rdata);
endinterface

// File: rtl/mmio_responder_seg_scanner.sv
// 8-digit multiplexed 7-segment driver: one digit per SCAN_DIV clocks,
// registered anode/cathode outputs that stay dark (0xFF) while in reset.
module seg_scanner
  import mmio_pkg::*;
#(
  parameter int SCAN_DIV = 20000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] seg_value,
  input  logic [7:0]  seg_blank,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] scan_cnt;
  logic [2:0]    digit;
  logic          wrap;
  logic [3:0]    nibble;

  assign wrap   = (scan_cnt == CW'(SCAN_DIV - 1));
  assign nibble = seg_value[{digit, 2'b00} +: 4];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      digit    <= '0;
      seg_an   <= 8'hFF;
      seg_cat  <= 8'hFF;
    end else begin
      scan_cnt <= wrap ? '0 : scan_cnt + CW'(1);
      if (wrap) digit <= digit + 3'd1;
      // A blanked digit turns every anode off rather than lighting a neighbour.
      seg_an  <= seg_blank[digit] ? 8'hFF : ~(8'h01 << digit);
      seg_cat <= {1'b1, SEG_FONT[nibble]};
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder for the I/O window (LEDs, switches, sticky buttons, 7-seg).
// Define MMIO_DEBOUNCE_EN to debounce switches/buttons on a shared tick.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 200000,
  parameter int SCAN_DIV        = 20000,
  parameter int SW_W            = 24,
  parameter int BTN_W           = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  mmio_responder_if.slave  bus,
  input  logic [SW_W-1:0]  switch_in,
  input  logic [BTN_W-1:0] button_in,
  output logic [SW_W-1:0]  led_out,
  output logic [7:0]       seg_an,
  output logic [7:0]       seg_cat
);

  localparam int IN_W = SW_W + BTN_W;

  if (DEBOUNCE_CYCLES < 2 || SCAN_DIV < 2) begin : g_param_check
    $error("mmio_responder: DEBOUNCE_CYCLES and SCAN_DIV must be >= 2");
  end

  logic [IN_W-1:0]  sync_a, sync_b, deb;
  logic [BTN_W-1:0] btn_q, press, flags;
  logic [SW_W-1:0]  led_q;
  logic [31:0]      seg_value;
  logic [7:0]       seg_blank;
  logic             clear;

  // Switches and buttons share one synchroniser/debounce path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= {button_in, switch_in};
      sync_b <= sync_a;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES);

  logic [DW-1:0]   tick_cnt;
  logic            tick;
  logic [IN_W-1:0] sample, stable, agree;

  assign tick  = (tick_cnt == DW'(DEBOUNCE_CYCLES - 1));
  assign agree = ~(sync_b ^ sample);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
      sample   <= '0;
      stable   <= '0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + DW'(1);
      if (tick) begin
        sample <= sync_b;
        // A bit only moves when two consecutive tick samples agree.
        stable <= (stable & ~agree) | (sync_b & agree);
      end
    end
  end

  assign deb = stable;
`else
  assign deb = sync_b;
`endif

  assign press = deb[IN_W-1:SW_W] & ~btn_q;
  assign clear = bus.io_read && !bus.io_write && (bus.addr_low == ADDR_BTN);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      btn_q     <= '0;
      flags     <= '0;
      led_q     <= '0;
      seg_value <= '0;
      seg_blank <= 8'hFF;
    end else begin
      btn_q <= deb[IN_W-1:SW_W];
      // A press on the clearing edge survives the clear.
      flags <= (clear ? '0 : flags) | press;
      if (bus.io_write) begin
        case (bus.addr_low)
          ADDR_LED:   led_q     <= bus.wdata[SW_W-1:0];
          ADDR_SEG:   seg_value <= bus.wdata;
          ADDR_BLANK: seg_blank <= bus.wdata[7:0];
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.io_read && !bus.io_write) begin
      case (bus.addr_low)
        ADDR_LED:   bus.rdata = 32'(led_q);
        ADDR_SW:    bus.rdata = 32'(deb[SW_W-1:0]);
        ADDR_SEG:   bus.rdata = seg_value;
        ADDR_BLANK: bus.rdata = 32'(seg_blank);
        ADDR_BTN:   bus.rdata = 32'(flags);
        default:    bus.rdata = '0;
      endcase
    end
  end

  assign led_out = led_q;

  seg_scanner #(.SCAN_DIV(SCAN_DIV)) u_scanner (
    .clock     (clock),
    .reset_n   (reset_n),
    .seg_value (seg_value),
    .seg_blank (seg_blank),
    .seg_an    (seg_an),
    .seg_cat   (seg_cat)
  );

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed scenarios plus random traffic checked
// against an edge-counting reference model of the register file and I/O.
module tb_mmio_responder;

  localparam int DEB   = 4;
  localparam int SD    = 4;
  localparam int SW_W  = 24;
  localparam int BTN_W = 5;
  localparam int IN_W  = SW_W + BTN_W;

  // ---------------- clock / reset ----------------
  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic [SW_W-1:0]  switch_in = '0;
  logic [BTN_W-1:0] button_in = '0;
  logic [SW_W-1:0]  led_out;
  logic [7:0]       seg_an, seg_cat;

  mmio_responder_if bus();

  mmio_responder #(
    .DEBOUNCE_CYCLES (DEB),
    .SCAN_DIV        (SD),
    .SW_W            (SW_W),
    .BTN_W           (BTN_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .switch_in (switch_in),
    .button_in (button_in),
    .led_out   (led_out),
    .seg_an    (seg_an),
    .seg_cat   (seg_cat)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] font [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int               e;              // rising edges since reset release
  logic [IN_W-1:0]  hist [4096];    // {buttons, switches} sampled at edge k
  logic [SW_W-1:0]  m_led;
  logic [31:0]      m_val;
  logic [7:0]       m_blank, exp_an, exp_cat;
  logic [BTN_W-1:0] m_flags, m_btn_prev;
  logic [IN_W-1:0]  m_sample, m_stable;

  // Two-stage synchroniser view after edge k: the raw input seen at edge k-1.
  function automatic logic [IN_W-1:0] sync_view(input int k);
    return (k >= 2) ? hist[(k - 1) % 4096] : '0;
  endfunction

  function automatic logic [IN_W-1:0] deb_view();
`ifdef MMIO_DEBOUNCE_EN
    return m_stable;
`else
    return sync_view(e);
`endif
  endfunction

  function automatic logic [31:0] model_rdata();
    logic [IN_W-1:0] d;
    d = deb_view();
    if (!bus.io_read || bus.io_write) return '0;
    case (bus.addr_low)
      10'h060: return 32'(m_led);
      10'h070: return 32'(d[SW_W-1:0]);
      10'h080: return m_val;
      10'h084: return 32'(m_blank);
      10'h090: return 32'(m_flags);
      default: return '0;
    endcase
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      e = 0; m_led = '0; m_val = '0; m_blank = 8'hFF; m_flags = '0;
      m_btn_prev = '0; m_sample = '0; m_stable = '0;
      exp_an = 8'hFF; exp_cat = 8'hFF;
    end else begin : model_step
      int idx;
      logic [IN_W-1:0] cur, samp, eq;
      idx = (e / SD) % 8;
      exp_an  = m_blank[idx] ? 8'hFF : ~(8'h01 << idx);
      exp_cat = font[m_val[idx*4 +: 4]];
      cur = deb_view();
      m_flags = ((bus.io_read && !bus.io_write && bus.addr_low == 10'h090) ? '0 : m_flags)
                | (cur[IN_W-1:SW_W] & ~m_btn_prev);
      m_btn_prev = cur[IN_W-1:SW_W];
      if (bus.io_write) begin
        case (bus.addr_low)
          10'h060: m_led   = bus.wdata[SW_W-1:0];
          10'h080: m_val   = bus.wdata;
          10'h084: m_blank = bus.wdata[7:0];
          default: ;
        endcase
      end
      e = e + 1;
      hist[e % 4096] = {button_in, switch_in};
`ifdef MMIO_DEBOUNCE_EN
      if (e % DEB == 0) begin
        samp = sync_view(e - 1);
        eq   = ~(samp ^ m_sample);
        m_stable = (m_stable & ~eq) | (samp & eq);
        m_sample = samp;
      end
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bus_cycle(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
    @(negedge clock);
    check_eq("led_out", 32'(led_out), 32'(m_led));
    check_eq("seg_an",  32'(seg_an),  32'(exp_an));
    check_eq("seg_cat", 32'(seg_cat), 32'(exp_cat));
    bus.io_read  = rd;
    bus.io_write = wr;
    bus.addr_low = a;
    bus.wdata    = d;
    #1;
    check_eq("rdata", bus.rdata, model_rdata());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 10'h000, 32'h0);
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus_cycle(1'b0, 1'b1, a, d);
  endtask

  task automatic rd(input logic [9:0] a);
    bus_cycle(1'b1, 1'b0, a, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  localparam int SETTLE = 4 * DEB + 4;
  logic [9:0] amap [6] = '{10'h060, 10'h070, 10'h080, 10'h084, 10'h090, 10'h000};

  initial begin
    bus.io_read = 1'b0; bus.io_write = 1'b0; bus.addr_low = '0; bus.wdata = '0;
    repeat (3) @(negedge clock);
    check_eq("rst_led", 32'(led_out), 32'h0);
    check_eq("rst_an",  32'(seg_an),  32'hFF);
    check_eq("rst_cat", 32'(seg_cat), 32'hFF);
    reset_n = 1'b1;
    idle(2);

    rd(10'h084); check_eq("rst_blank_rd", bus.rdata, 32'hFF);
    rd(10'h090); check_eq("rst_btn_rd",   bus.rdata, 32'h0);

    wr(10'h060, 32'h00A5_A5A5);
    idle(1);     check_eq("led_written", 32'(led_out), 32'hA5A5A5);
    rd(10'h060); check_eq("led_rd",      bus.rdata,    32'h00A5_A5A5);
    wr(10'h070, 32'hFFFF_FFFF);
    rd(10'h070); check_eq("sw_ro",       bus.rdata,    32'h0);
    rd(10'h060); check_eq("led_kept",    bus.rdata,    32'h00A5_A5A5);
    bus_cycle(1'b1, 1'b1, 10'h060, 32'h0000_1234);
    check_eq("rw_both_rdata", bus.rdata, 32'h0);

    wr(10'h080, 32'h7654_3210);
    wr(10'h084, 32'h0);
    idle(8 * SD * 2 + 4);
    wr(10'h084, 32'h02);
    idle(8 * SD * 2);

    switch_in = 24'h123456;
`ifdef MMIO_DEBOUNCE_EN
    idle(SETTLE);
    rd(10'h070); check_eq("sw_settled", bus.rdata, 32'h123456);
    switch_in = '0;
    for (int i = 0; i < DEB; i++) begin
      rd(10'h070); check_eq("sw_glitch_hidden", bus.rdata, 32'h123456);
    end
    switch_in = 24'h123456;
    for (int i = 0; i < SETTLE; i++) begin
      rd(10'h070); check_eq("sw_after_glitch", bus.rdata, 32'h123456);
    end
`else
    rd(10'h070); check_eq("sw_1clk", bus.rdata, 32'h0);
    rd(10'h070); check_eq("sw_2clk", bus.rdata, 32'h123456);
    switch_in = '0;
    idle(3);
    switch_in = 24'h123456;
    idle(3);
`endif

    button_in = 5'b00100;
    idle(SETTLE);
    button_in = '0;
    idle(SETTLE);
    rd(10'h090); check_eq("btn_press", bus.rdata, 32'h04);
    rd(10'h090); check_eq("btn_cleared", bus.rdata, 32'h0);

    // Sweep the clearing read across the press latency so one read lands on it.
    for (int k = 0; k < SETTLE + 4; k++) begin
      button_in = 5'b00100;
      idle(k);
      rd(10'h090);
      rd(10'h090);
      button_in = '0;
      idle(SETTLE);
      rd(10'h090);
    end

    idle(7);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_an",  32'(seg_an),  32'hFF);
    check_eq("midrst_cat", 32'(seg_cat), 32'hFF);
    check_eq("midrst_led", 32'(led_out), 32'h0);
    idle(3);
    reset_n = 1'b1;
    idle(2);
    rd(10'h084); check_eq("post_rst_blank", bus.rdata, 32'hFF);

    for (int i = 0; i < 1500; i++) begin : random_phase
      int op;
      logic [9:0] a;
      op = $urandom_range(0, 9);
      a  = amap[$urandom_range(0, 5)];
      if (a == 10'h000) a = 10'($urandom);
      if ($urandom_range(0, 29) == 0) switch_in = 24'($urandom);
      if ($urandom_range(0, 14) == 0) button_in = 5'($urandom);
      if (op <= 2)      rd(a);
      else if (op <= 4) wr(a, $urandom);
      else if (op == 5) bus_cycle(1'b1, 1'b1, a, $urandom);
      else              idle(1);
    end

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder for the single-cycle CPU.
- Serves the I/O window at 0xFFFFFC00–0xFFFFFFFF, i.e. the accesses the controller flags with io_read and io_write instead of data memory.
- Owns the board LEDs, the switches, the buttons (sticky press flags) and an 8-digit multiplexed 7-segment display.
- Returns read data to the write-back mux.

Parameters:
- DEBOUNCE_CYCLES, 200000, clocks between debounce samples (must be ≥2).
- SCAN_DIV, 20000, clocks per 7-seg digit slot (must be ≥2).
- SW_W, 24, switch and LED width.
- BTN_W, 5, button count.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- io_read  in  1  CPU load targets the I/O window.
- io_write  in  1  CPU store targets the I/O window.
- addr_low  in  10  ALU result bits [9:0], byte address inside the window.
- wdata  in  32  store data.
- rdata  out  32  load data.
- switch_in  in  SW_W  raw switches, asynchronous to clock.
- button_in  in  BTN_W  raw buttons, asynchronous, active-high.
- led_out  out  SW_W  LED drive.
- seg_an  out  8  digit anodes, active-low.
- seg_cat  out  8  segments {dp,g..a}, active-low.

Behaviour:
- Address map (addr_low):
  - 0x060 LED register, RW, bits [SW_W-1:0].
  - 0x070 switches, RO, debounced value.
  - 0x080 seg_value, RW, 8 hex nibbles; nibble i drives digit i.
  - 0x084 seg_blank, RW, bits [7:0]; bit i=1 blanks digit i.
  - 0x090 btn_status, RO, sticky press flags [BTN_W-1:0]; clear-on-read.
- Writes: the register is updated at the clock edge where io_write=1 and the address matches. Unmapped or read-only addresses: write ignored. io_read and io_write both high: treat as write only, no read side effects.
- Reads: rdata is combinational and valid in the same cycle io_read=1; unused upper bits are 0. Unmapped address or io_read=0: rdata=0.
- Input synchronisation: switch_in and button_in each pass through a 2-FF synchroniser.
- Debounce: a shared counter produces a 1-cycle tick every DEBOUNCE_CYCLES clocks. On each tick the synchronised value is sampled. A per-bit stable value is updated only when the current sample equals the previous tick's sample.
- Button press: a rising edge of a debounced button sets its sticky flag.
- Clear-on-read: the edge where io_read=1 at 0x090 clears all flags. If a press lands on that same edge, the set wins for that bit.
- Scan: the counter counts 0..SCAN_DIV-1 and wraps; on wrap, digit index 0..7 advances and wraps 7→0.
  - Active digit: seg_an has a single 0 at the index, unless that digit is blanked, in which case all anodes are 1.
  - seg_cat = hex font (0–F) of the nibble; dp always off (1).
- Reset values, asynchronous, held while reset_n=0:
  - led_out=0, seg_value=0, seg_blank=0xFF, seg_an=0xFF, seg_cat=0xFF.
  - Digit index 0, all counters 0, synchronisers, debounced values and sticky flags all 0.
- Reset asserted mid-scan or mid-debounce: state returns to the reset values immediately; operation restarts cleanly after release.

Optional Feature:
- MMIO_DEBOUNCE_EN defined: debounce as described above.
- Undefined: the debounced value equals the 2-FF synchronised value directly. Tick counter removed; button edge detection runs every clock.

Decomposition:
- Package mmio_pkg: address constants (LED/SW/SEG/BLANK/BTN offsets), I/O window base 0xFFFFFC00, 16-entry 7-seg font table.
- One sub-module, seg_scanner: scan counter, digit index, font lookup, anode/cathode drive. Inputs are seg_value and seg_blank.

Test Plan:
Run with DEBOUNCE_CYCLES=4 and SCAN_DIV=4.
- Reset then idle: led_out=0, seg_an=0xFF, seg_cat=0xFF. Read 0x084 returns 0xFF; read 0x090 returns 0.
- Write 0x060=0x00A5A5A5 → led_out=0xA5A5A5 on the next edge; read 0x060 → 0x00A5A5A5. Write to 0x070 → no change anywhere.
- Write 0x080=0x76543210 and 0x084=0x00 → anodes step 0xFE,0xFD,…,0x7F, each held 4 clocks, then wrap to 0xFE. Digit 0 cathodes = 0xC0 (glyph "0").
- Write 0x084=0x02 → digit-1 slot shows seg_an=0xFF; the other slots are unchanged.
- switch_in=0x123456 with a 1-tick glitch to 0 → read 0x070 eventually 0x123456; the glitch is never visible. Macro off: value visible 2 clocks after the change.
- Press button 2 → read 0x090=0x04; next read=0x00. Press landing on the clearing read edge → next read=0x04.
